// File: rtl/lookahead_compare_pipe.sv
// rtl/lookahead_compare_pipe.sv - two-stage grouped magnitude/equality comparator with valid/ready flow control
module lookahead_compare_pipe #(
    parameter int WIDTH = 32,
    parameter int GROUP = 4,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             signed_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             isLessThan,
    output logic             isNotEqual,
    output logic             isGreaterThan,
    output logic [TAG_W-1:0] out_tag
);

    localparam int NG = WIDTH / GROUP;
    localparam int NB = (NG + 3) / 4;

    if ((WIDTH % GROUP) != 0 || (WIDTH / GROUP) < 2) begin : g_bad_params
        $error("lookahead_compare_pipe: WIDTH must be a multiple of GROUP with at least two groups");
    end

    logic             adv1;
    logic             adv2;

    logic             v1_d, v1_q;
    logic [NG-1:0]    ne_d, ne_q;
    logic [NG-1:0]    lt_d, lt_q;
    logic [TAG_W-1:0] tag1_d, tag1_q;

    logic             v2_d, v2_q;
    logic             lt2_d, lt2_q;
    logic             ne2_d, ne2_q;
    logic             gt2_d, gt2_q;
    logic [TAG_W-1:0] tag2_d, tag2_q;

    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] b_eff;
    logic [4*NB-1:0]  ne_pad;
    logic [4*NB-1:0]  lt_pad;
    logic [NB-1:0]    blk_ne;
    logic [NB-1:0]    blk_lt;
    logic             ne_all;
    logic             lt_all;

    always_comb begin
        adv2     = ~v2_q | out_ready;
        adv1     = ~v1_q | adv2;
        in_ready = adv1;
    end

    // Flipping both sign bits in signed mode turns the top-group MSB compare into a two's-complement one.
    always_comb begin
        a_eff            = data_operandA;
        b_eff            = data_operandB;
        a_eff[WIDTH-1]   = data_operandA[WIDTH-1] ^ signed_mode;
        b_eff[WIDTH-1]   = data_operandB[WIDTH-1] ^ signed_mode;

        v1_d   = v1_q;
        ne_d   = ne_q;
        lt_d   = lt_q;
        tag1_d = tag1_q;
        if (adv1) begin
            v1_d = in_valid;
        end
        if (adv1 && in_valid) begin
            tag1_d = in_tag;
            for (int g = 0; g < NG; g++) begin
                ne_d[g] = 1'b0;
                lt_d[g] = 1'b0;
                for (int i = 0; i < GROUP; i++) begin
                    if (a_eff[g*GROUP+i] != b_eff[g*GROUP+i]) begin
                        ne_d[g] = 1'b1;
                        lt_d[g] = b_eff[g*GROUP+i];
                    end
                end
            end
        end
    end

    // Lookahead merge: resolve blocks of four groups, then pick the highest differing block.
    always_comb begin
        ne_pad         = '0;
        lt_pad         = '0;
        ne_pad[NG-1:0] = ne_q;
        lt_pad[NG-1:0] = lt_q;
        blk_ne         = '0;
        blk_lt         = '0;
        for (int k = 0; k < NB; k++) begin
            for (int j = 0; j < 4; j++) begin
                if (ne_pad[4*k+j]) begin
                    blk_ne[k] = 1'b1;
                    blk_lt[k] = lt_pad[4*k+j];
                end
            end
        end
        ne_all = 1'b0;
        lt_all = 1'b0;
        for (int k = 0; k < NB; k++) begin
            if (blk_ne[k]) begin
                ne_all = 1'b1;
                lt_all = blk_lt[k];
            end
        end
    end

    always_comb begin
        v2_d   = v2_q;
        lt2_d  = lt2_q;
        ne2_d  = ne2_q;
        gt2_d  = gt2_q;
        tag2_d = tag2_q;
        if (adv2) begin
            v2_d = v1_q;
        end
        if (adv2 && v1_q) begin
            lt2_d  = lt_all;
            ne2_d  = ne_all;
            gt2_d  = ne_all & ~lt_all;
            tag2_d = tag1_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            v1_q   <= 1'b0;
            ne_q   <= '0;
            lt_q   <= '0;
            tag1_q <= '0;
            v2_q   <= 1'b0;
            lt2_q  <= 1'b0;
            ne2_q  <= 1'b0;
            gt2_q  <= 1'b0;
            tag2_q <= '0;
        end else begin
            v1_q   <= v1_d;
            ne_q   <= ne_d;
            lt_q   <= lt_d;
            tag1_q <= tag1_d;
            v2_q   <= v2_d;
            lt2_q  <= lt2_d;
            ne2_q  <= ne2_d;
            gt2_q  <= gt2_d;
            tag2_q <= tag2_d;
        end
    end

    always_comb begin
        out_valid     = v2_q;
        isLessThan    = lt2_q;
        isNotEqual    = ne2_q;
        isGreaterThan = gt2_q;
        out_tag       = tag2_q;
    end

endmodule

// File: tb/tb_lookahead_compare_pipe.sv
// tb/tb_lookahead_compare_pipe.sv - scoreboard bench for lookahead_compare_pipe
module tb_lookahead_compare_pipe;

    localparam int W  = 32;
    localparam int TW = 5;

    typedef struct packed {
        logic          lt;
        logic          ne;
        logic          gt;
        logic [TW-1:0] tag;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  data_operandA = '0;
    logic [W-1:0]  data_operandB = '0;
    logic          signed_mode = 1'b0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          isLessThan;
    logic          isNotEqual;
    logic          isGreaterThan;
    logic [TW-1:0] out_tag;

    exp_t exp_q[$];
    exp_t mon_exp;
    exp_t mon_got;
    int   checks = 0;
    int   errors = 0;
    int   n_out = 0;
    int   cyc = 0;
    int   bp_lo = -10;
    int   bp_hi = -10;
    logic force_stall = 1'b0;
    logic rand_bp = 1'b0;
    logic stall_seen = 1'b0;

    lookahead_compare_pipe #(.WIDTH(W), .GROUP(4), .TAG_W(TW)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .signed_mode   (signed_mode),
        .in_tag        (in_tag),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .isLessThan    (isLessThan),
        .isNotEqual    (isNotEqual),
        .isGreaterThan (isGreaterThan),
        .out_tag       (out_tag)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        out_ready = !(force_stall || (cyc >= bp_lo && cyc <= bp_hi) ||
                      (rand_bp && $urandom_range(0, 2) == 0));
    end

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s, input logic [TW-1:0] t);
        exp_t r;
        r.lt  = s ? ($signed(a) < $signed(b)) : (a < b);
        r.ne  = (a != b);
        r.gt  = r.ne && !r.lt;
        r.tag = t;
        return r;
    endfunction

    always @(negedge clock) begin
        #2;
        if (reset_n && out_valid && out_ready) begin
            checks++;
            mon_got = {isLessThan, isNotEqual, isGreaterThan, out_tag};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result got lt/ne/gt/tag=%b/%b/%b/%0d with nothing expected",
                         isLessThan, isNotEqual, isGreaterThan, out_tag);
            end else begin
                mon_exp = exp_q.pop_front();
                n_out++;
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL result got lt/ne/gt/tag=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                             mon_got.lt, mon_got.ne, mon_got.gt, mon_got.tag,
                             mon_exp.lt, mon_exp.ne, mon_exp.gt, mon_exp.tag);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, want);
        end
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [TW-1:0] t);
        int n;
        n = 0;
        @(negedge clock);
        in_valid      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        signed_mode   = s;
        in_tag        = t;
        #1;
        while (!in_ready && n < 200) begin
            stall_seen = 1'b1;
            @(negedge clock);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout tag=%0d in_ready stuck at 0", t);
        end else begin
            exp_q.push_back(model(a, b, s, t));
            @(posedge clock);
        end
    endtask

    task automatic idle();
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        repeat (2) @(negedge clock);
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic rand_vec(output logic [W-1:0] a, output logic [W-1:0] b);
        int k;
        a = $urandom;
        b = $urandom;
        k = $urandom_range(0, W - 1);
        case ($urandom_range(0, 3))
            0: ;
            1: b = a;
            2: b = a ^ (32'h1 << k);
            default: begin
                a = {{(W-8){a[7]}}, a[7:0]};
                b = {{(W-8){b[7]}}, b[7:0]};
            end
        endcase
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int           start_out;

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #3;
        check("reset_out_valid", out_valid, 0);
        check("reset_flags", {isLessThan, isNotEqual, isGreaterThan}, 0);
        check("reset_out_tag", out_tag, 0);
        check("reset_in_ready", in_ready, 1);

        issue(32'h0000_0005, 32'h0000_0009, 1'b0, 5'd3);
        @(negedge clock);
        in_valid = 1'b0;
        #3;
        check("latency_cycle1_valid", out_valid, 0);
        @(negedge clock);
        #3;
        check("latency_cycle2_valid", out_valid, 1);
        check("first_result", {isLessThan, isNotEqual, isGreaterThan, out_tag}, {3'b110, 5'd3});

        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 5'd4);
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 5'd5);
        issue(32'h8000_0000, 32'h8000_0000, 1'b1, 5'd6);
        issue(32'h8000_0000, 32'h8000_0000, 1'b0, 5'd7);
        issue(32'h1234_5670, 32'h1234_5671, 1'b0, 5'd8);
        issue(32'h1234_5670, 32'h1234_5671, 1'b1, 5'd9);
        issue(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 5'd10);
        issue(32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 5'd11);
        idle();
        drain();

        stall_seen = 1'b0;
        start_out  = n_out;
        bp_lo      = cyc + 3;
        bp_hi      = cyc + 6;
        for (int i = 0; i < 8; i++) begin
            rand_vec(ra, rb);
            issue(ra, rb, 1'($urandom_range(0, 1)), 5'(i));
        end
        idle();
        drain();
        check("backpressure_in_ready_dropped", stall_seen, 1);
        check("backpressure_result_count", n_out - start_out, 8);

        force_stall = 1'b1;
        issue(32'h0000_0001, 32'h0000_0002, 1'b0, 5'd20);
        issue(32'h0000_0003, 32'h0000_0002, 1'b0, 5'd21);
        @(negedge clock);
        reset_n       = 1'b0;
        in_valid      = 1'b1;
        data_operandA = 32'h0000_0010;
        data_operandB = 32'h0000_0020;
        in_tag        = 5'd22;
        @(posedge clock);
        @(negedge clock);
        reset_n     = 1'b1;
        in_valid    = 1'b0;
        exp_q.delete();
        force_stall = 1'b0;
        #3;
        check("midreset_in_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            check("midreset_out_valid_low", out_valid, 0);
            @(negedge clock);
            #3;
        end
        issue(32'hFFFF_FFF0, 32'h0000_0010, 1'b1, 5'd23);
        idle();
        drain();

        rand_bp = 1'b1;
        for (int i = 0; i < 400; i++) begin
            rand_vec(ra, rb);
            issue(ra, rb, 1'($urandom_range(0, 1)), 5'($urandom));
        end
        idle();
        rand_bp = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

endmodule

// File: doc/lookahead_compare_pipe.md
# lookahead_compare_pipe

Parametrised, two-stage pipelined magnitude/equality comparator with a valid/ready handshake and a per-transaction signed/unsigned mode. It splits the operands into fixed-width groups, resolves each group in stage 1, and merges the group results most-significant-first in stage 2. It sits between the register-read stage and the branch-resolve logic, feeding `blt`/`bne`-class decisions. It passes a tag through so results can be matched to in-flight instructions.

## Interface
- `WIDTH`, 32: operand width in bits. Must be a multiple of `GROUP` and at least 2·`GROUP`.
- `GROUP`, 4: bits resolved per stage-1 group. `NG = WIDTH/GROUP` groups.
- `TAG_W`, 5: width of the pass-through tag.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  input transaction present.
- `in_ready`  out  1  block accepts an input this cycle.
- `data_operandA`  in  WIDTH  operand A.
- `data_operandB`  in  WIDTH  operand B.
- `signed_mode`  in  1  1 = two's-complement compare, 0 = unsigned.
- `in_tag`  in  TAG_W  opaque tag.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer takes the result this cycle.
- `isLessThan`  out  1  A < B under the captured mode.
- `isNotEqual`  out  1  A ≠ B.
- `isGreaterThan`  out  1  A > B, equal to `isNotEqual & ~isLessThan`.
- `out_tag`  out  TAG_W  tag of the presented result.

## Operation
- Input transfer: `in_valid & in_ready`. Output transfer: `out_valid & out_ready`.
- **Stage 1**
  - For each group g: `ne_g` = any bit differs.
  - `lt_g` = at the most-significant differing bit within the group, A has 0 and B has 1.
  - Top group (g = NG−1), signed mode: the group's MSB comparison is inverted. A MSB 1 / B MSB 0 means less-than.
  - Register `ne[NG-1:0]`, `lt[NG-1:0]`, tag and valid bit `v1`.
- **Stage 2**
  - `isNotEqual` = OR of all `ne_g`.
  - `isLessThan` = `lt_g` of the highest g with `ne_g` = 1; 0 if none.
  - Merge is a two-level lookahead tree: groups of 4, then across groups. Equivalent to a priority encoder.
  - Register the results, tag and valid bit `v2`.
- **Flow control**
  - Pipeline with full throughput and backpressure; no bubbles inserted when the consumer is ready.
  - `adv2 = ~v2 | out_ready`; `adv1 = ~v1 | adv2`; `in_ready = adv1`.
  - Stage 2 loads from stage 1 when `adv2`; `v2 <= v1`.
  - Stage 1 loads the input when `adv1`; `v1 <= in_valid`.
  - Stalled stages hold data and tag unchanged.
- **Outputs**
  - `out_valid = v2`.
  - `isLessThan`/`isNotEqual`/`isGreaterThan`/`out_tag` are the stage-2 registers.
  - While `out_valid` = 0 their values are don't-care for consumers, but they hold their last value.
- **Mode capture**: `signed_mode` is captured with its operands. Changing it later does not affect in-flight results.
- **Parameter errors**: illegal parameters (`WIDTH % GROUP ≠ 0`, or `NG < 2`) cause an elaboration-time error.

## Timing
- **Latency**: exactly 2 cycles from input transfer to `out_valid` when unstalled.
- **Throughput**: 1 result per cycle.
- **Reset** (`reset_n` = 0 at a clock edge):
  - `v1`, `v2`, `out_valid`, `isLessThan`, `isNotEqual`, `isGreaterThan` and `out_tag` clear to 0.
  - `in_ready` reads 1 from the first cycle after reset.
- **Reset mid-operation**: all in-flight transactions are discarded, none are presented afterwards, and inputs offered in the reset cycle are dropped.
- **Full pipeline with `out_ready` = 0**: `in_ready` = 0 combinationally. No input is lost and no result is overwritten.
- **Simultaneous transfer**: output transfer and input transfer in the same cycle with both stages full. Both stages shift and `in_ready` stays 1.
- **Combinational paths**: `in_ready` depends combinationally on `out_ready`. There is no combinational path from operands to outputs.

## Test plan
- Reset, then unsigned A=0x0000_0005, B=0x0000_0009, tag 3 → 2 cycles later `out_valid`=1, LT=1, NE=1, GT=0, `out_tag`=3.
- Signed A=0xFFFF_FFFF (−1), B=0x0000_0001 → LT=1. The same operands unsigned → LT=0, GT=1.
- A=B=0x8000_0000 in both modes → NE=0, LT=0, GT=0. Also cover A=0x1234_5670, B=0x1234_5671 (difference only in group 0) → LT=1.
- Stream 8 back-to-back random vectors with tags 0–7 while `out_ready` is held 0 from cycle 3 to 6:
  - `in_ready` drops once both stages are full.
  - All 8 results appear in order, with no loss or duplication, and match the reference model.
- Assert `reset_n`=0 for one cycle while two transactions are in flight → `out_valid` stays 0 until a new input is accepted.
- Build variants WIDTH=16/GROUP=4 and WIDTH=64/GROUP=8 → run 10k random signed/unsigned vectors against a behavioural `<`/`!=` model with zero mismatches.
